// File: rtl/imem_pkg.sv
// imem_pkg: shared types and constants for the instruction-memory responder.
//   state_e  - responder FSM states
//   NOP      - instruction word returned on a faulting fetch
//   CNT_W    - wait-state counter width (WAIT range 0..15)
//   addr_err - misaligned / out-of-range fetch decode
package imem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam logic [31:0] NOP   = 32'h0000_0000;
  localparam int unsigned CNT_W = 4;

  // A fetch faults when the byte address is not word aligned or when any
  // bit above the word-index field is set.
  function automatic logic addr_err(input logic [31:0] addr,
                                    input int unsigned addr_w);
    logic [31:0] hi;
    hi = addr >> (addr_w + 2);
    return (addr[1:0] != 2'b00) || (hi != '0);
  endfunction

endpackage

// File: rtl/imem_array.sv
// imem_array: instruction store, one synchronous write port and one
// synchronous read port. A read and a write to the same word in the same
// cycle return the old contents. Only the read-data register is reset; the
// store itself keeps its contents across reset.
//   clk, rst  - clock, asynchronous active-low reset (read register only)
//   we/wa/wd  - write enable, word index, data
//   re/ra     - read enable, word index
//   rd_data   - registered read data, holds between reads
module imem_array #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned DATA_W  = 32,
  parameter logic [31:0] RST_VAL = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  input  logic              re,
  input  logic [ADDR_W-1:0] ra,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_q [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] rd_data_d, rd_data_q;

  always_ff @(posedge clk) begin
    if (we) mem_q[wa] <= wd;
  end

  // mem_q is sampled before this edge's write lands: read-before-write.
  always_comb begin
    rd_data_d = rd_data_q;
    if (re) rd_data_d = mem_q[ra];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rd_data_q <= DATA_W'(RST_VAL);
    else      rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/imem_responder.sv
// imem_responder: memory-side end of the instruction fetch interface.
// Accepts a PC byte address on a valid/ready request channel, waits WAIT
// cycles, and returns the instruction word on a valid/ready response channel.
// Faulting fetches return NOP_INSTR with rsp_err set, with unchanged latency.
//   clk, rst                      - clock, asynchronous active-low reset
//   req_valid/req_ready/req_addr  - fetch request channel
//   rsp_valid/rsp_ready           - response handshake
//   rsp_instr/rsp_addr/rsp_err    - response payload (stable while stalled)
//   ld_en/ld_addr/ld_data         - write-only load port into the store
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned WAIT      = 1,
  parameter logic [31:0] NOP_INSTR = NOP
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [31:0]       req_addr,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_instr,
  output logic [31:0]       rsp_addr,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [31:0]       ld_data
);

  localparam logic [CNT_W-1:0] WAIT_CNT = CNT_W'(WAIT);

  state_e            state_d, state_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;
  logic [31:0]       addr_d, addr_q;
  logic              err_d, err_q;

  logic              accept;
  logic              req_err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;

  assign req_err   = addr_err(req_addr, ADDR_W);
  // In RESP the slot frees in the same cycle the response is consumed.
  assign req_ready = rst && ((state_q == ST_IDLE) ||
                             ((state_q == ST_RESP) && rsp_ready));
  assign accept    = req_valid && req_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    rd_addr = addr_q[ADDR_W+1:2];

    case (state_q)
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q <= 1) begin
          rd_en   = !err_q;
          state_d = ST_RESP;
          cnt_d   = '0;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_d = ST_IDLE;
      end
      default: ;
    endcase

    // Shared by IDLE and RESP: accept always wins over the return to IDLE.
    if (accept) begin
      addr_d = req_addr;
      err_d  = req_err;
      cnt_d  = WAIT_CNT;
      if (WAIT == 0) begin
        // Zero wait states: read straight from the incoming address.
        rd_en   = !req_err;
        rd_addr = req_addr[ADDR_W+1:2];
        state_d = ST_RESP;
      end else begin
        state_d = ST_WAIT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      err_q   <= err_d;
    end
  end

  imem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (32),
    .RST_VAL(NOP_INSTR)
  ) u_array (
    .clk    (clk),
    .rst    (rst),
    .we     (ld_en && rst),
    .wa     (ld_addr),
    .wd     (ld_data),
    .re     (rd_en),
    .ra     (rd_addr),
    .rd_data(rd_data)
  );

  // A faulting fetch never reads the store, so the payload is forced here.
  assign rsp_valid = (state_q == ST_RESP);
  assign rsp_instr = err_q ? NOP_INSTR : rd_data;
  assign rsp_addr  = addr_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

  localparam int unsigned AW = 10;
  localparam int N = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic [31:0] req_addr;
  logic        rsp_ready;
  logic        ld_en;
  logic [AW-1:0] ld_addr;
  logic [31:0] ld_data;

  logic        req_ready_o [N];
  logic        rsp_valid_o [N];
  logic [31:0] rsp_instr_o [N];
  logic [31:0] rsp_addr_o  [N];
  logic        rsp_err_o   [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Instance k uses wait_of(k) wait states; all share the same inputs.
  function automatic int wait_of(input int k);
    case (k)
      0:       return 1;
      1:       return 0;
      default: return 3;
    endcase
  endfunction

  imem_responder #(.ADDR_W(AW), .WAIT(1), .NOP_INSTR(32'h0000_0000)) u_w1 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[0]),
    .req_addr(req_addr), .rsp_valid(rsp_valid_o[0]), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr_o[0]), .rsp_addr(rsp_addr_o[0]), .rsp_err(rsp_err_o[0]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  imem_responder #(.ADDR_W(AW), .WAIT(0), .NOP_INSTR(32'h0000_0000)) u_w0 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[1]),
    .req_addr(req_addr), .rsp_valid(rsp_valid_o[1]), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr_o[1]), .rsp_addr(rsp_addr_o[1]), .rsp_err(rsp_err_o[1]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  imem_responder #(.ADDR_W(AW), .WAIT(3), .NOP_INSTR(32'h0000_0000)) u_w3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready_o[2]),
    .req_addr(req_addr), .rsp_valid(rsp_valid_o[2]), .rsp_ready(rsp_ready),
    .rsp_instr(rsp_instr_o[2]), .rsp_addr(rsp_addr_o[2]), .rsp_err(rsp_err_o[2]),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data));

  // ---------------- reference model (transaction level) ----------------
  // Each instance holds at most one fetch. A fetch accepted on edge number c
  // samples the store on edge c+WAIT (before that edge's load) and is shown
  // from then until it is consumed.
  logic [31:0] mem_m [0:31];
  bit          pend_m [N];
  bit          val_m  [N];
  bit          err_m  [N];
  logic [31:0] addr_m [N];
  logic [31:0] instr_m[N];
  int          due_m  [N];
  int          cyc = 0;

  function automatic bit exp_err(input logic [31:0] a);
    return (a % 4 != 0) || (longint'(a) >= (longint'(1) << (AW + 2)));
  endfunction

  initial begin
    for (int k = 0; k < N; k++) begin
      pend_m[k] = 0; val_m[k] = 0; err_m[k] = 0;
      addr_m[k] = '0; instr_m[k] = '0; due_m[k] = 0;
    end
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        for (int k = 0; k < N; k++) begin
          pend_m[k] = 0;
          val_m[k]  = 0;
        end
      end else if (clk) begin
        cyc++;
        for (int k = 0; k < N; k++) begin
          bit rdy;
          logic [31:0] a;
          rdy = !pend_m[k] || (val_m[k] && rsp_ready);
          if (pend_m[k] && val_m[k] && rsp_ready) begin
            pend_m[k] = 0;
            val_m[k]  = 0;
          end
          if (req_valid && rdy) begin
            pend_m[k] = 1;
            val_m[k]  = 0;
            addr_m[k] = req_addr;
            err_m[k]  = exp_err(req_addr);
            due_m[k]  = cyc + wait_of(k);
          end
          if (pend_m[k] && !val_m[k] && cyc == due_m[k]) begin
            val_m[k] = 1;
            a = addr_m[k];
            instr_m[k] = err_m[k] ? 32'h0 : mem_m[a[6:2]];
          end
        end
        if (ld_en) mem_m[ld_addr[4:0]] = ld_data;
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  initial begin
    forever begin
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
        if (!rst) begin
          chk($sformatf("rst_req_ready[%0d]", k), 32'(req_ready_o[k]), 32'd0);
          chk($sformatf("rst_rsp_valid[%0d]", k), 32'(rsp_valid_o[k]), 32'd0);
          chk($sformatf("rst_rsp_instr[%0d]", k), rsp_instr_o[k], 32'h0);
          chk($sformatf("rst_rsp_addr[%0d]", k), rsp_addr_o[k], 32'h0);
          chk($sformatf("rst_rsp_err[%0d]", k), 32'(rsp_err_o[k]), 32'd0);
        end else begin
          chk($sformatf("req_ready[%0d]", k), 32'(req_ready_o[k]),
              32'(!pend_m[k] || (val_m[k] && rsp_ready)));
          chk($sformatf("rsp_valid[%0d]", k), 32'(rsp_valid_o[k]),
              32'(pend_m[k] && val_m[k]));
          if (pend_m[k] && val_m[k]) begin
            chk($sformatf("rsp_instr[%0d]", k), rsp_instr_o[k], instr_m[k]);
            chk($sformatf("rsp_addr[%0d]", k), rsp_addr_o[k], addr_m[k]);
            chk($sformatf("rsp_err[%0d]", k), 32'(rsp_err_o[k]), 32'(err_m[k]));
          end
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    ld_en     = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic fetch1(input logic [31:0] a);
    req_valid = 1'b1;
    req_addr  = a;
    tick();
    req_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    #2 rst = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();

    // Preload words 0..31.
    for (int i = 0; i < 32; i++) begin
      ld_en   = 1'b1;
      ld_addr = AW'(i);
      case (i)
        0:       ld_data = 32'h2008_0005;
        1:       ld_data = 32'h2009_0007;
        2:       ld_data = 32'h012A_4020;
        3:       ld_data = 32'hAAAA_0003;
        default: ld_data = $urandom;
      endcase
      tick();
    end
    idle(2);

    // Basic fetch, WAIT=1: valid on the second edge after acceptance.
    rsp_ready = 1'b1;
    fetch1(32'h0);
    @(negedge clk);
    chk("t1_w1_not_yet", 32'(rsp_valid_o[0]), 32'd0);
    chk("t1_w0_valid", 32'(rsp_valid_o[1]), 32'd1);
    tick();
    @(negedge clk);
    chk("t1_valid", 32'(rsp_valid_o[0]), 32'd1);
    chk("t1_instr", rsp_instr_o[0], 32'h2008_0005);
    chk("t1_addr", rsp_addr_o[0], 32'h0);
    chk("t1_err", 32'(rsp_err_o[0]), 32'd0);
    idle(6);

    // Back-to-back on the WAIT=0 instance.
    req_valid = 1'b1; req_addr = 32'h0; tick();
    req_addr = 32'h4;
    @(negedge clk);
    chk("t2_r0_instr", rsp_instr_o[1], 32'h2008_0005);
    chk("t2_r0_addr", rsp_addr_o[1], 32'h0);
    tick();
    req_addr = 32'h8;
    @(negedge clk);
    chk("t2_r1_instr", rsp_instr_o[1], 32'h2009_0007);
    chk("t2_r1_addr", rsp_addr_o[1], 32'h4);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t2_r2_valid", 32'(rsp_valid_o[1]), 32'd1);
    chk("t2_r2_instr", rsp_instr_o[1], 32'h012A_4020);
    idle(6);

    // Misaligned and out-of-range fetches.
    fetch1(32'h2);
    @(negedge clk);
    chk("t3_mis_err", 32'(rsp_err_o[1]), 32'd1);
    chk("t3_mis_instr", rsp_instr_o[1], 32'h0);
    idle(6);
    fetch1(32'h1000);
    @(negedge clk);
    chk("t3_oor_err", 32'(rsp_err_o[1]), 32'd1);
    chk("t3_oor_instr", rsp_instr_o[1], 32'h0);
    idle(6);

    // Back-pressure, then same-cycle hand-over.
    rsp_ready = 1'b0;
    fetch1(32'hC);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(rsp_valid_o[1]), 32'd1);
      chk("t4_hold_instr", rsp_instr_o[1], 32'hAAAA_0003);
      chk("t4_hold_ready", 32'(req_ready_o[1]), 32'd0);
      tick();
    end
    rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h4;
    @(negedge clk);
    chk("t4_handover_ready", 32'(req_ready_o[1]), 32'd1);
    tick();
    req_valid = 1'b0;
    @(negedge clk);
    chk("t4_next_addr", rsp_addr_o[1], 32'h4);
    chk("t4_next_instr", rsp_instr_o[1], 32'h2009_0007);
    idle(6);

    // Reset while the WAIT=3 instance is counting.
    fetch1(32'h8);
    tick();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_rst_valid", 32'(rsp_valid_o[2]), 32'd0);
    chk("t5_rst_addr", rsp_addr_o[2], 32'h0);
    tick(); tick();
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("t5_dropped", 32'(rsp_valid_o[2]), 32'd0);
      tick();
    end
    fetch1(32'h8);
    tick(); tick();
    @(negedge clk);
    chk("t5_fresh_early", 32'(rsp_valid_o[2]), 32'd0);
    tick();
    @(negedge clk);
    chk("t5_fresh_valid", 32'(rsp_valid_o[2]), 32'd1);
    chk("t5_fresh_instr", rsp_instr_o[2], 32'h012A_4020);
    idle(6);

    // Load collides with the read of word 3 on the WAIT=1 instance.
    fetch1(32'hC);
    ld_en = 1'b1; ld_addr = AW'(3); ld_data = 32'hBBBB_0003;
    tick();
    ld_en = 1'b0;
    @(negedge clk);
    chk("t6_old_valid", 32'(rsp_valid_o[0]), 32'd1);
    chk("t6_old_instr", rsp_instr_o[0], 32'hAAAA_0003);
    idle(6);
    fetch1(32'hC);
    tick();
    @(negedge clk);
    chk("t6_new_instr", rsp_instr_o[0], 32'hBBBB_0003);
    idle(6);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      int unsigned r;
      rst       = ($urandom_range(0, 199) != 0);
      rsp_ready = ($urandom_range(0, 3) != 0);
      req_valid = ($urandom_range(0, 2) != 0);
      r = $urandom_range(0, 9);
      if (r <= 6)      req_addr = 32'($urandom_range(0, 31)) * 4;
      else if (r == 7) req_addr = 32'($urandom_range(0, 31)) * 4 + 32'($urandom_range(1, 3));
      else if (r == 8) req_addr = 32'h1000 + 32'($urandom_range(0, 15)) * 4;
      else             req_addr = $urandom | 32'h8000_0000;
      ld_en   = ($urandom_range(0, 4) == 0);
      ld_addr = AW'($urandom_range(0, 31));
      ld_data = $urandom;
      tick();
    end
    rst = 1'b1;
    rsp_ready = 1'b1;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
